instr_encoder: RTL

- Inverse of the instruction decoder. Accepts one decoded-field record per handshake (op_type, rs1, rs2, rd, offset, immediate) and produces the matching 32-bit RV instruction word.
- Tags each word with a running byte address and streams it out through a one-entry registered valid/ready port.
- Feeds the instruction-memory loader and the self-check bench, which round-trips words through the decoder.
- op_type codes are the shared instruction-header codes: I_ADD, I_ADDI, I_ADDW, I_BEQ, I_BNE, I_BLT, I_LW, I_SW, I_JAL, I_NULL, I_ERR.

---
 rtl/instr_encoder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Field-record to RV32 instruction encoder with a one-entry registered output stage.
// Each emitted word is tagged with a running byte address; rejected records raise err.
module instr_encoder #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_type,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       offset,
  input  logic [31:0]       immediate,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  count
);

  localparam logic [4:0] I_ADD  = 5'd0;
  localparam logic [4:0] I_ADDI = 5'd1;
  localparam logic [4:0] I_ADDW = 5'd2;
  localparam logic [4:0] I_BEQ  = 5'd3;
  localparam logic [4:0] I_BNE  = 5'd4;
  localparam logic [4:0] I_BLT  = 5'd5;
  localparam logic [4:0] I_LW   = 5'd6;
  localparam logic [4:0] I_SW   = 5'd7;
  localparam logic [4:0] I_JAL  = 5'd8;
  localparam logic [4:0] I_NULL = 5'd9;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_OP    = 2'b01;
  localparam logic [1:0] E_RANGE = 2'b10;
  localparam logic [1:0] E_ALIGN = 2'b11;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state, state_nxt;
  logic [31:0]       word;
  logic [1:0]        code;
  logic [2:0]        br_f3;
  logic              accept, good, bad;
  logic [ADDR_W-1:0] next_addr, tag_addr;

  // Sign-extension checks: the bits above each field's MSB must replicate it.
  logic imm12_ok, off12_ok, off13_ok, off21_ok;
  assign imm12_ok = (&immediate[31:11]) | ~(|immediate[31:11]);
  assign off12_ok = (&offset[31:11]) | ~(|offset[31:11]);
  assign off13_ok = (&offset[31:12]) | ~(|offset[31:12]);
  assign off21_ok = (&offset[31:20]) | ~(|offset[31:20]);

  assign br_f3 = (op_type == I_BEQ) ? 3'b000 : (op_type == I_BNE) ? 3'b001 : 3'b100;

  // Word assembly and rejection reason; code wins over word when non-zero.
  always_comb begin
    word = '0;
    code = E_NONE;
    case (op_type)
      I_ADD:  word = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
      I_ADDW: word = {7'b0, rs2, rs1, 3'b000, rd, 7'b0111011};
      I_ADDI: begin
        word = {immediate[11:0], rs1, 3'b000, rd, 7'b0010011};
        if (!imm12_ok) code = E_RANGE;
      end
      I_LW: begin
        word = {offset[11:0], rs1, 3'b010, rd, 7'b0000011};
        if (!off12_ok) code = E_RANGE;
      end
      I_SW: begin
        word = {offset[11:5], rs2, rs1, 3'b010, offset[4:0], 7'b0100011};
        if (!off12_ok) code = E_RANGE;
      end
      I_BEQ, I_BNE, I_BLT: begin
        word = {offset[12], offset[10:5], rs2, rs1, br_f3, offset[4:1], offset[11], 7'b1100011};
        if (offset[0])      code = E_ALIGN;
        else if (!off13_ok) code = E_RANGE;
      end
      I_JAL: begin
        word = {offset[20], offset[10:1], offset[11], offset[19:12], rd, 7'b1101111};
        if (offset[0])      code = E_ALIGN;
        else if (!off21_ok) code = E_RANGE;
      end
      I_NULL:  word = '0;
      default: code = E_OP;
    endcase
  end

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign good      = accept & (code == E_NONE);
  assign bad       = accept & (code != E_NONE);
  assign tag_addr  = base_load ? base_addr : next_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (good) state_nxt = FULL;
      FULL:  if (out_ready) state_nxt = good ? FULL : EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output word, address tagging, error reporting and emitted-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_instr <= '0;
      out_addr  <= '0;
      next_addr <= '0;
      err       <= 1'b0;
      err_code  <= E_NONE;
      count     <= '0;
    end else begin
      err <= bad;
      if (bad) err_code <= code;
      if (good) begin
        out_instr <= word;
        out_addr  <= tag_addr;
        next_addr <= tag_addr + ADDR_W'(4);
      end else if (base_load) begin
        next_addr <= base_addr;
      end
      if (out_valid && out_ready && (count != '1)) count <= count + CNT_W'(1);
    end
  end

endmodule
